// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the rv32i core. It steps each instruction
//   through FETCH -> DECODE -> EXEC -> (MEM) -> WB around the registered
//   decoder. It handshakes with instruction and data memory and generates the
//   IR, PC and register-file write strobes. It also counts retired
//   instructions and traps memory time-outs into a sticky error state.
//
//   Memory handshake: a request (imem_req / dmem_req) stays high for every
//   cycle the FSM sits in FETCH / MEM. A cycle with the request high and the
//   matching ack high completes the transfer. Acks seen in any other state are
//   ignored.
//
// Parameters
//   MEM_TIMEOUT  max cycles a FETCH/MEM request waits for ack (>= 1)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   run                 1 = execute, 0 = stop at the next instruction boundary
//   imem_req/imem_ack   instruction fetch request / data valid
//   ir_we               latch the fetched word into IR
//   is_load, is_store,
//   is_halt, reg_we     registered decoder outputs
//   br_taken            branch condition true, or JAL/JALR
//   dmem_req/dmem_we    data request / write qualifier
//   dmem_ack            data access complete
//   rf_we, pc_we        register-file and PC write strobes
//   pc_sel              0 = PC+4, 1 = ALU target
//   state               current FSM state (debug)
//   halted              core is in HALT
//   err                 sticky memory time-out flag
//   retired             instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module core_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_we,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_halt,
   input  logic             reg_we,
   input  logic             br_taken,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   // The wait counter only has to reach MEM_TIMEOUT-1: the cycle that would
   // make it reach MEM_TIMEOUT is the one that decides the time-out.
   localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t             st;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               err_q;
   logic [CNT_W-1:0]   retired_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IDLE;
         wait_cnt  <= '0;
         err_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         case (st)
            S_IDLE: begin
               if (run) begin
                  st       <= S_FETCH;
                  wait_cnt <= '0;
               end
            end
            S_FETCH: begin
               // An ack on the limit cycle still wins over the time-out.
               if (imem_ack) begin
                  st <= S_DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  st    <= S_ERROR;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               st <= S_EXEC;
            end
            S_EXEC: begin
               if (is_halt) begin
                  st <= S_HALT;
               end else if (is_load || is_store) begin
                  st       <= S_MEM;
                  wait_cnt <= '0;
               end else begin
                  st <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  st <= S_WB;
               end else if (wait_cnt == WAIT_LAST) begin
                  st    <= S_ERROR;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_WB: begin
               retired_q <= retired_q + CNT_W'(1);
               if (run) begin
                  st       <= S_FETCH;
                  wait_cnt <= '0;
               end else begin
                  st <= S_IDLE;
               end
            end
            // HALT and ERROR only leave through rst.
            S_HALT:  st <= S_HALT;
            S_ERROR: st <= S_ERROR;
            default: st <= S_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the current state so they drop in the same
   // cycle a reset or state change takes effect.
   assign imem_req = (st == S_FETCH);
   assign ir_we    = (st == S_FETCH) && imem_ack;
   assign dmem_req = (st == S_MEM);
   assign dmem_we  = (st == S_MEM) && is_store;
   assign rf_we    = (st == S_WB) && reg_we && !is_store;
   assign pc_we    = (st == S_WB);
   assign pc_sel   = (st == S_WB) && br_taken;

   assign state    = st;
   assign halted   = (st == S_HALT);
   assign err      = err_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//   Directed bench for core_sequencer (MEM_TIMEOUT=4, CNT_W=3). Each
//   instruction pushes its expected write-back signature into exp_q. A monitor
//   pops one entry on every pc_we cycle. The same always block also acts as the
//   memory responder, with programmable ack delays.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

   localparam int TO = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic          imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel;
   logic          imem_ack = 1'b0;
   logic          dmem_ack = 1'b0;
   logic          is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0;
   logic          reg_we = 1'b0, br_taken = 1'b0;
   logic [2:0]    state;
   logic          halted, err;
   logic [CW-1:0] retired;

   core_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
      .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
      .reg_we(reg_we), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .state(state), .halted(halted), .err(err), .retired(retired)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   // Signature: {rf_we, pc_sel, dmem_we_seen, mem_cycles[3:0], latency[7:0], ir_we_count[1:0]}
   logic [16:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int exp_ret = 0;

   int imem_delay = 0;
   int dmem_delay = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [16:0] sig(input logic rf, input logic sel, input logic dwe,
                                       input int memc, input int lat, input int irc);
      return {rf, sel, dwe, 4'(memc), 8'(lat), 2'(irc)};
   endfunction

   // ---------------- responder + monitor ----------------
   int         wi = 0, wd = 0;
   int         cyc = 0, irc = 0, memc = 0;
   logic       dwe_seen = 1'b0;
   logic [2:0] prev_state = 3'd0;
   logic [16:0] obs;

   always begin
      @(negedge clk);
      // Memory model: ack after the programmed number of wait cycles.
      if (imem_req) begin
         imem_ack = (wi == imem_delay);
         wi++;
      end else begin
         imem_ack = 1'b0;
         wi = 0;
      end
      if (dmem_req) begin
         dmem_ack = (wd == dmem_delay);
         wd++;
      end else begin
         dmem_ack = 1'b0;
         wd = 0;
      end
      #1;
      if (state == 3'd1 && prev_state != 3'd1) begin
         cyc = 0; irc = 0; memc = 0; dwe_seen = 1'b0;
      end
      cyc++;
      if (ir_we)    irc++;
      if (dmem_req) memc++;
      if (dmem_we)  dwe_seen = 1'b1;
      if (pc_we) begin
         obs = sig(rf_we, pc_sel, dwe_seen, memc, cyc, irc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wb: act=0x%0h req=none", obs);
         end else begin
            check("wb_signature", 32'(obs), 32'(exp_q.pop_front()));
         end
      end
      prev_state = state;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_state(input logic [2:0] s, input string name);
      int n = 0;
      while (state != s && n < 50) begin
         step();
         n++;
      end
      if (state != s) begin
         total++;
         bad++;
         $display("FAIL %s: act=state%0d req=state%0d", name, state, s);
      end
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      run = 1'b0;
      step();
      rst = 1'b0;
      exp_ret = 0;
   endtask

   task automatic set_dec(input logic ld, input logic stv, input logic ht,
                          input logic rw, input logic br);
      is_load = ld; is_store = stv; is_halt = ht; reg_we = rw; br_taken = br;
   endtask

   // One instruction from IDLE; run drops in DECODE so the FSM stops after WB.
   task automatic run_one(input string name, input logic ld, input logic stv,
                          input logic rw, input logic br, input int idly, input int ddly,
                          input logic erf, input logic esel, input logic edwe,
                          input int ememc, input int elat);
      set_dec(ld, stv, 1'b0, rw, br);
      imem_delay = idly;
      dmem_delay = ddly;
      exp_q.push_back(sig(erf, esel, edwe, ememc, elat, 1));
      run = 1'b1;
      wait_state(3'd2, {name, "_decode"});
      run = 1'b0;
      wait_state(3'd0, {name, "_idle"});
      exp_ret++;
      check({name, "_retired"}, 32'(retired), 32'(exp_ret % (1 << CW)));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      step();
      check("rst_state",   32'(state), 0);
      check("rst_retired", 32'(retired), 0);
      check("rst_err",     32'(err), 0);
      check("rst_halted",  32'(halted), 0);
      check("rst_strobes", 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}), 0);
      rst = 1'b0;
      step();
      check("idle_hold", 32'(state), 0);

      //        name     ld  st  rw  br  idly ddly rf  sel dwe mem lat
      run_one("add",   0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4);
      run_one("lw",    1, 0, 1, 0, 0, 3, 1, 0, 0, 4, 8);
      run_one("sw",    0, 1, 1, 0, 0, 3, 0, 0, 1, 4, 8);
      run_one("beq_t", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4);
      run_one("beq_n", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
      run_one("jal",   0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 4);
      run_one("add_w", 0, 0, 1, 0, 3, 0, 1, 0, 0, 0, 7);
      run_one("addi",  0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4);
      check("wrap_retired", 32'(retired), 0);
      check("no_err", 32'(err), 0);

      // Fetch time-out: ack never comes.
      do_reset();
      set_dec(0, 0, 0, 1, 0);
      imem_delay = 1000;
      run = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (state == 3'd7) break;
         if (imem_req) n++;
      end
      check("to_fetch_cycles", 32'(n), TO);
      check("to_state", 32'(state), 7);
      check("to_err", 32'(err), 1);
      check("to_imem_req", 32'(imem_req), 0);
      for (int i = 0; i < 4; i++) begin
         run = ~run;
         step();
      end
      check("to_sticky_err", 32'(err), 1);
      check("to_sticky_state", 32'(state), 7);
      do_reset();
      check("to_rst_err", 32'(err), 0);
      check("to_rst_state", 32'(state), 0);

      // Data time-out.
      set_dec(1, 0, 0, 1, 0);
      imem_delay = 0;
      dmem_delay = 1000;
      run = 1'b1;
      wait_state(3'd4, "mto_mem");
      wait_state(3'd7, "mto_error");
      check("mto_err", 32'(err), 1);
      check("mto_dmem_req", 32'(dmem_req), 0);

      // Halt.
      do_reset();
      set_dec(0, 0, 1, 0, 0);
      imem_delay = 0;
      run = 1'b1;
      wait_state(3'd6, "halt_enter");
      check("halt_flag", 32'(halted), 1);
      for (int i = 0; i < 4; i++) begin
         run = ~run;
         step();
         check("halt_pc_we", 32'(pc_we), 0);
      end
      check("halt_stay", 32'(state), 6);
      do_reset();
      check("halt_rst_state", 32'(state), 0);
      check("halt_rst_flag", 32'(halted), 0);

      // Reset in the middle of a data access.
      run_one("add2", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4);
      set_dec(1, 0, 0, 1, 0);
      dmem_delay = 1000;
      run = 1'b1;
      wait_state(3'd4, "rmem_mem");
      check("rmem_req_before", 32'(dmem_req), 1);
      rst = 1'b1;
      run = 1'b0;
      step();
      check("rmem_req_after", 32'(dmem_req), 0);
      check("rmem_state", 32'(state), 0);
      check("rmem_retired", 32'(retired), 0);
      rst = 1'b0;
      step();

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
